// File: rtl/wave_plot_ctrl.sv
// wave_plot_ctrl: oscilloscope-style trace plotter, codec samples -> VGA pixel writes.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   enable         1 = run continuous frames, 0 = stop after current column
//   read_ready     codec has a sample; sample is 24-bit two's complement data
//   read           pop strobe to codec (mirrors read_ready)
//   x, y, colour   VGA pixel coordinates/colour, valid when plot=1, held otherwise
//   plot           VGA write strobe
//   busy           any state other than IDLE
//   frame_done     one-cycle pulse after column 159 is drawn
module wave_plot_ctrl #(
   parameter int          DECIM        = 64,
   parameter logic [2:0]  COLOUR       = 3'b111,
   parameter int          TRIG_TIMEOUT = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        read_ready,
   input  logic [23:0] sample,
   output logic        read,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        frame_done
);
   localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, CAPTURE = 3'd2, ERASE = 3'd3, DRAW = 3'd4, NEXT = 3'd5;
   logic [2:0]        state;
   logic [7:0]        col, x_q;
   logic [15:0]       dcnt, tcnt;
   logic              prev, seeded;
   logic [159:0]      valid;
   logic [6:0]        old_y [160];
   logic [6:0]        y_new, y_q, y_map;
   logic [2:0]        c_q;
   logic              acc, dec, trig, timeout;
   logic signed [8:0] diff;
   logic              sample_unused;
   assign sample_unused = ^sample[16:0];
   // The codec FIFO is always drained; only ARM/CAPTURE actually consume samples.
   assign read    = read_ready & ~reset;
   assign acc     = read && (state == ARM || state == CAPTURE);
   assign dec     = acc && dcnt == 16'(DECIM - 1);
   assign trig    = seeded && prev && !sample[23];
   assign timeout = seeded && tcnt == 16'(TRIG_TIMEOUT - 1);
   // Top 7 bits as a signed row offset around the screen centre, clamped to 0..119.
   assign diff  = 9'sd60 - $signed({{2{sample[23]}}, sample[23:17]});
   assign y_map = diff[8] ? 7'd0 : (diff > 9'sd119 ? 7'd119 : diff[6:0]);
   assign plot       = !reset && (state == DRAW || (state == ERASE && valid[col]));
   assign x          = plot ? col : x_q;
   assign y          = !plot ? y_q : (state == DRAW ? y_new : old_y[col]);
   assign colour     = !plot ? c_q : (state == DRAW ? COLOUR : 3'b000);
   assign busy       = state != IDLE;
   assign frame_done = state == NEXT && col == 8'd159;
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         col    <= 8'd0;
         dcnt   <= 16'd0;
         tcnt   <= 16'd0;
         prev   <= 1'b0;
         seeded <= 1'b0;
         valid  <= '0;
         y_new  <= 7'd0;
         x_q    <= 8'd0;
         y_q    <= 7'd0;
         c_q    <= 3'b000;
      end else begin
         if (acc) dcnt <= dec ? 16'd0 : dcnt + 16'd1;
         if (plot) begin
            x_q <= x;
            y_q <= y;
            c_q <= colour;
         end
         case (state)
            IDLE: if (enable) begin
               state  <= ARM;
               col    <= 8'd0;
               dcnt   <= 16'd0;
               tcnt   <= 16'd0;
               seeded <= 1'b0;
            end
            ARM: if (dec) begin
               // First decimated sample after entry only seeds the edge detector.
               prev   <= sample[23];
               seeded <= 1'b1;
               if (trig || timeout) begin
                  y_new <= y_map;
                  state <= ERASE;
               end else if (seeded) tcnt <= tcnt + 16'd1;
            end
            CAPTURE: if (dec) begin
               y_new <= y_map;
               state <= ERASE;
            end
            ERASE: state <= DRAW;
            DRAW: begin
               valid[col] <= 1'b1;
               state      <= NEXT;
            end
            NEXT: if (col == 8'd159) begin
               col    <= 8'd0;
               tcnt   <= 16'd0;
               seeded <= 1'b0;
               state  <= enable ? ARM : IDLE;
            end else begin
               col   <= col + 8'd1;
               state <= enable ? CAPTURE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Column store has no reset; the valid vector guards every read of it.
   always_ff @(posedge clk)
      if (!reset && state == DRAW) old_y[col] <= y_new;
endmodule
